// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART receiver, LSB first. Produces one byte per correctly framed
//   character as a single-cycle strobe; a low stop bit gives a single-cycle
//   framing_error strobe instead, and the receiver then waits for the line to
//   return high before hunting for the next start bit.
// Ports
//   clk                system clock
//   reset              asynchronous, active-low reset
//   rx                 raw UART line, idle high, asynchronous to clk
//   source_data_valid  1-cycle strobe: source_data holds a new byte
//   source_data        last correctly framed byte
//   framing_error      1-cycle strobe: stop bit sampled low
//   rx_busy            high whenever the receiver is not idle
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       source_data_valid,
  output logic [7:0] source_data,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;

  // Synchroniser pair plus one delay flop for edge detection; all idle high.
  logic rx_meta_q, rx_s_q, rx_d_q;
  logic fall;

  assign fall = rx_d_q & ~rx_s_q;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end

      S_START: begin
        if (baud_q == HALF_LAST) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            baud_d    = '0;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          baud_d  = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (rx_s_q) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          baud_d = baud_q + CNT_ONE;
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered from next state so rx_busy tracks the state register exactly.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_d_q    <= 1'b1;
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_d_q    <= rx_s_q;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign source_data_valid = valid_q;
  assign source_data       = data_q;
  assign framing_error     = ferr_q;
  assign rx_busy           = busy_q;

endmodule
